// File: rtl/kn_chunk_responder_if.sv
// Chunk request/response bundle between the chunk consumer (master) and the
// key/nonce/counter responder (slave).
interface kn_chunk_responder_if;
  logic        chunk_request;
  logic [1:0]  request_type;
  logic [4:0]  chunk_index;
  logic [31:0] chunk;
  logic [1:0]  chunk_type;
  logic        chunk_valid;

  modport master (
    output chunk_request, request_type, chunk_index,
    input  chunk, chunk_type, chunk_valid
  );

  modport slave (
    input  chunk_request, request_type, chunk_index,
    output chunk, chunk_type, chunk_valid
  );
endinterface

// File: rtl/kn_chunk_responder.sv
// Serves 32-bit key/nonce/counter words, one registered pulse per accepted
// request, with optional post-serve counter auto-increment.
module kn_chunk_responder #(
  parameter int unsigned RESP_DELAY = 1,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [255:0]                key_in,
  input  logic [95:0]                 nonce_in,
  input  logic [31:0]                 counter_in,
  kn_chunk_responder_if.slave         bus,
  output logic [31:0]                 counter_out,
  output logic                        busy,
  output logic                        err
);

  typedef enum logic [1:0] {StIdle, StWait, StPulse, StHold} state_e;

  state_e            state_q, state_d;
  logic [7:0][31:0]  key_q;
  logic [2:0][31:0]  nonce_q;
  logic [31:0]       counter_q, counter_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        type_q, type_d;
  logic [6:0]        tag_q, tag_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       chunk_q, chunk_d;
  logic [1:0]        ctype_q, ctype_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic [6:0]        live_tag;
  logic              legal;
  logic [31:0]       sel_word;
  logic              inc;

  // Decode the live tag and pick the word from the current registers.
  always_comb begin
    live_tag = {bus.request_type, bus.chunk_index};
    legal    = 1'b0;
    sel_word = '0;
    case (bus.request_type)
      2'b00: begin
        legal    = (bus.chunk_index < 5'd8);
        sel_word = key_q[bus.chunk_index[2:0]];
      end
      2'b01: begin
        legal = (bus.chunk_index < 5'd3);
        case (bus.chunk_index[1:0])
          2'd0:    sel_word = nonce_q[0];
          2'd1:    sel_word = nonce_q[1];
          2'd2:    sel_word = nonce_q[2];
          default: sel_word = '0;
        endcase
      end
      2'b10: begin
        legal    = (bus.chunk_index == 5'd0);
        sel_word = counter_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    type_d  = type_q;
    tag_d   = tag_q;
    chunk_d = '0;
    ctype_d = '0;
    valid_d = 1'b0;
    err_d   = load ? 1'b0 : err_q;
    inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.chunk_request) begin
          tag_d = live_tag;
          if (legal) begin
            word_d  = sel_word;
            type_d  = bus.request_type;
            cnt_d   = 4'(RESP_DELAY - 1);
            state_d = StWait;
          end else begin
            err_d   = 1'b1;
            state_d = StHold;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StPulse;
          valid_d = 1'b1;
          chunk_d = word_q;
          ctype_d = type_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPulse: begin
        state_d = StHold;
        inc     = AUTO_INC && (type_q == 2'b10);
      end
      StHold: begin
        // Same tag still held: already served, wait for release or a new tag.
        if (!bus.chunk_request || (live_tag != tag_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    counter_d = counter_q;
    if (load)     counter_d = counter_in;
    else if (inc) counter_d = counter_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      key_q     <= '0;
      nonce_q   <= '0;
      counter_q <= '0;
      word_q    <= '0;
      type_q    <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      chunk_q   <= '0;
      ctype_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (load) begin
        key_q   <= key_in;
        nonce_q <= nonce_in;
      end
      counter_q <= counter_d;
      word_q    <= word_d;
      type_q    <= type_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      chunk_q   <= chunk_d;
      ctype_q   <= ctype_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign bus.chunk       = chunk_q;
  assign bus.chunk_type  = ctype_q;
  assign bus.chunk_valid = valid_q;
  assign counter_out     = counter_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule

// File: tb/tb_kn_chunk_responder.sv
// Directed bench: one responder with RESP_DELAY=1 and one with RESP_DELAY=3
// share the same stimulus.
module tb_kn_chunk_responder;

  localparam logic [255:0] KeyVal =
    256'hDEADBEEF_CAFEF00D_01020304_05060708_DEADBEEF_CAFEF00D_01020304_05060708;
  localparam logic [95:0]  NonceVal = 96'h12345678_9ABCDEF0_FEDCBA98;

  logic         clk = 1'b0;
  logic         rst, load, req;
  logic [1:0]   rtype;
  logic [4:0]   ridx;
  logic [255:0] key_in;
  logic [95:0]  nonce_in;
  logic [31:0]  counter_in;
  logic [31:0]  counter_out1, counter_out3;
  logic         busy1, busy3, err1, err3;
  int           checks = 0;
  int           errors = 0;

  kn_chunk_responder_if b1 ();
  kn_chunk_responder_if b3 ();

  assign b1.chunk_request = req;
  assign b1.request_type  = rtype;
  assign b1.chunk_index   = ridx;
  assign b3.chunk_request = req;
  assign b3.request_type  = rtype;
  assign b3.chunk_index   = ridx;

  kn_chunk_responder #(.RESP_DELAY(1), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .key_in(key_in), .nonce_in(nonce_in),
    .counter_in(counter_in), .bus(b1), .counter_out(counter_out1), .busy(busy1), .err(err1)
  );

  kn_chunk_responder #(.RESP_DELAY(3), .AUTO_INC(1'b1)) dut3 (
    .clk(clk), .rst(rst), .load(load), .key_in(key_in), .nonce_in(nonce_in),
    .counter_in(counter_in), .bus(b3), .counter_out(counter_out3), .busy(busy3), .err(err3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one request on the RESP_DELAY=1 responder and release it.
  task automatic serve1(input logic [1:0] t, input logic [4:0] i, input logic [31:0] exp,
                        input string tag);
    int n = 0;
    req = 1'b1; rtype = t; ridx = i;
    do begin step(); n++; end while (!b1.chunk_valid && n < 10);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_word"}, b1.chunk, exp);
    chk({tag, "_type"}, {30'd0, b1.chunk_type}, {30'd0, t});
    req = 1'b0;
    step();
    chk({tag, "_once"}, {31'd0, b1.chunk_valid}, 32'd0);
    step();
  endtask

  task automatic illegal(input logic [1:0] t, input logic [4:0] i, input string tag);
    int pulses = 0;
    req = 1'b1; rtype = t; ridx = i;
    repeat (5) begin
      step();
      if (b1.chunk_valid) pulses++;
    end
    chk({tag, "_nopulse"}, pulses, 0);
    chk({tag, "_err"}, {31'd0, err1}, 32'd1);
    req = 1'b0;
    step();
    step();
  endtask

  initial begin
    int          pulses, at;
    logic [31:0] word;
    logic [31:0] kexp [4];
    kexp = '{32'h05060708, 32'h01020304, 32'hCAFEF00D, 32'hDEADBEEF};

    // Reset with random inputs.
    rst = 1'b1;
    repeat (2) begin
      req        = 1'($urandom);
      rtype      = 2'($urandom);
      ridx       = 5'($urandom);
      load       = 1'($urandom);
      key_in     = {8{$urandom}};
      nonce_in   = {3{$urandom}};
      counter_in = $urandom;
      @(posedge clk);
    end
    #1;
    chk("rst_chunk", b1.chunk, 32'd0);
    chk("rst_type", {30'd0, b1.chunk_type}, 32'd0);
    chk("rst_valid", {31'd0, b1.chunk_valid}, 32'd0);
    chk("rst_counter", counter_out1, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_valid3", {31'd0, b3.chunk_valid}, 32'd0);
    req = 1'b0; load = 1'b0; rtype = 2'd0; ridx = 5'd0; rst = 1'b0;

    // Key service.
    key_in = KeyVal; nonce_in = NonceVal; counter_in = 32'hA0B0C0D0;
    load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 8; i++) serve1(2'b00, 5'(i), kexp[i % 4], $sformatf("key%0d", i));

    // Nonce and counter service.
    serve1(2'b01, 5'd0, 32'hFEDCBA98, "nonce0");
    serve1(2'b01, 5'd1, 32'h9ABCDEF0, "nonce1");
    serve1(2'b01, 5'd2, 32'h12345678, "nonce2");
    serve1(2'b10, 5'd0, 32'hA0B0C0D0, "ctr");
    chk("ctr_inc", counter_out1, 32'hA0B0C0D1);
    counter_in = 32'hFFFFFFFF; load = 1'b1; step(); load = 1'b0;
    serve1(2'b10, 5'd0, 32'hFFFFFFFF, "ctr_max");
    chk("ctr_wrap", counter_out1, 32'h00000000);

    // Illegal requests.
    illegal(2'b11, 5'd0, "ill_type");
    illegal(2'b00, 5'd8, "ill_key8");
    illegal(2'b10, 5'd1, "ill_ctr1");
    serve1(2'b00, 5'd3, 32'hDEADBEEF, "after_ill");
    chk("err_sticky", {31'd0, err1}, 32'd1);
    load = 1'b1; step(); load = 1'b0;
    chk("err_clear", {31'd0, err1}, 32'd0);

    // Load beats increment on the same edge.
    counter_in = 32'h00000010; load = 1'b1; step(); load = 1'b0;
    req = 1'b1; rtype = 2'b10; ridx = 5'd0;
    step(); step();
    chk("coll_valid", {31'd0, b1.chunk_valid}, 32'd1);
    chk("coll_word", b1.chunk, 32'h00000010);
    counter_in = 32'h00000005; load = 1'b1; req = 1'b0;
    step(); load = 1'b0;
    chk("coll_ctr", counter_out1, 32'h00000005);
    step();

    // Load during WAIT keeps the in-flight word.
    req = 1'b1; rtype = 2'b00; ridx = 5'd0;
    step();
    key_in = {8{32'h11111111}}; load = 1'b1;
    step(); load = 1'b0;
    chk("ldwait_valid", {31'd0, b1.chunk_valid}, 32'd1);
    chk("ldwait_word", b1.chunk, 32'h05060708);
    req = 1'b0; step(); step();

    // Load on the acceptance edge serves the old registers.
    key_in = KeyVal; load = 1'b1; req = 1'b1; ridx = 5'd1;
    step(); load = 1'b0;
    step();
    chk("ldacc_valid", {31'd0, b1.chunk_valid}, 32'd1);
    chk("ldacc_word", b1.chunk, 32'h11111111);
    req = 1'b0; step(); step();

    // Reset during WAIT drops the pulse.
    req = 1'b1; ridx = 5'd0;
    step();
    rst = 1'b1; step(); rst = 1'b0; req = 1'b0;
    chk("rstw_busy", {31'd0, busy1}, 32'd0);
    pulses = 0;
    repeat (4) begin step(); if (b1.chunk_valid) pulses++; end
    chk("rstw_nopulse", pulses, 0);

    // Held request on the RESP_DELAY=3 responder: one pulse at N+3.
    load = 1'b1; step(); load = 1'b0;
    req = 1'b1; rtype = 2'b00; ridx = 5'd2;
    pulses = 0; at = 0; word = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (b3.chunk_valid) begin pulses++; at = k; word = b3.chunk; end
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_lat", at, 4);
    chk("hold_word", word, 32'hCAFEF00D);
    chk("hold_busy", {31'd0, busy3}, 32'd1);
    req = 1'b0; step(); step();

    // Request dropped during WAIT is still served.
    req = 1'b1; ridx = 5'd3;
    step(); req = 1'b0;
    pulses = 0; at = 0; word = '0;
    for (int k = 2; k <= 8; k++) begin
      step();
      if (b3.chunk_valid) begin pulses++; at = k; word = b3.chunk; end
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_lat", at, 4);
    chk("drop_word", word, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
